// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the 4-bank transposed FIR MAC sequencer.
package fir_seq_pkg;

    localparam int NUM_BANKS     = 4;
    localparam int TAPS_PER_BANK = 10;
    localparam int MAX_COEFF     = 40;
    localparam int COEFF_W       = 16;
    localparam int TAP_W         = 4;
    localparam int BANK_W        = 2;
    localparam int NCOEF_W       = 6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UPDATE = 3'd1,
        FETCH  = 3'd2,
        DRAIN  = 3'd3,
        ADD    = 3'd4
    } seqState_e;

    function automatic logic [NCOEF_W-1:0] clampNcoef(input logic [NCOEF_W-1:0] n);
        if (n > 6'd40) begin
            return 6'd40;
        end else begin
            return n;
        end
    endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Host/sample-side inputs and SRAM/MAC-side outputs of the FIR MAC sequencer.
interface fir_mac_sequencer_if;
    import fir_seq_pkg::*;

    logic                        iEnSample_600k;
    logic                        iCoeffiUpdateFlag;
    logic                        iCsnRam;
    logic                        iWrnRam;
    logic [BANK_W-1:0]           iBankSel;
    logic [TAP_W-1:0]            iAddrRam;
    logic signed [COEFF_W-1:0]   iWrDtRam;
    logic [NCOEF_W-1:0]          iNumOfCoeff;

    logic [NUM_BANKS-1:0]        oCsnRam;
    logic                        oWrnRam;
    logic [TAP_W-1:0]            oAddrRam;
    logic signed [COEFF_W-1:0]   oWrDtRam;
    logic                        oEnDelay;
    logic [NUM_BANKS-1:0]        oEnMul;
    logic [NUM_BANKS-1:0]        oEnAcc;
    logic                        oEnAdd;
    logic                        oBusy;
    logic                        oOverrun;

    modport master (
        output iEnSample_600k, iCoeffiUpdateFlag, iCsnRam, iWrnRam,
               iBankSel, iAddrRam, iWrDtRam, iNumOfCoeff,
        input  oCsnRam, oWrnRam, oAddrRam, oWrDtRam, oEnDelay,
               oEnMul, oEnAcc, oEnAdd, oBusy, oOverrun
    );

    modport slave (
        input  iEnSample_600k, iCoeffiUpdateFlag, iCsnRam, iWrnRam,
               iBankSel, iAddrRam, iWrDtRam, iNumOfCoeff,
        output oCsnRam, oWrnRam, oAddrRam, oWrDtRam, oEnDelay,
               oEnMul, oEnAcc, oEnAdd, oBusy, oOverrun
    );

endinterface

// File: rtl/fir_bank_active_calc.sv
// Registers the number of active taps in each bank, clamp(Ncoef - 10*b, 0, 10),
// when a new sample sweep is accepted.
module fir_bank_active_calc
    import fir_seq_pkg::*;
(
    input  logic                            iClk_12M,
    input  logic                            iRsn,
    input  logic                            iLoad,
    input  logic [NCOEF_W-1:0]              iNumCoeff,
    output logic [NUM_BANKS-1:0][TAP_W-1:0] oAct
);

    function automatic logic [TAP_W-1:0] bankActive(input logic [NCOEF_W-1:0] n, input int b);
        logic [6:0] lo;
        logic [6:0] hi;
        logic [6:0] nx;
        lo = 7'(TAPS_PER_BANK * b);
        hi = lo + 7'(TAPS_PER_BANK);
        nx = {1'b0, n};
        if (nx >= hi) begin
            return 4'(TAPS_PER_BANK);
        end else if (nx > lo) begin
            return 4'(nx - lo);
        end else begin
            return 4'd0;
        end
    endfunction

    // Per-bank active tap counts, captured once per accepted strobe.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            oAct <= '0;
        end else if (iLoad) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                oAct[b] <= bankActive(iNumCoeff, b);
            end
        end else begin
            oAct <= oAct;
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Per-sample scheduler for the 4-bank FIR datapath: host coefficient routing and
// parallel bank sweep. Optional sticky overrun flag: define FIR_SEQ_OVERRUN_EN.
module fir_mac_sequencer
    import fir_seq_pkg::*;
(
    input  logic              iClk_12M,
    input  logic              iRsn,
    fir_mac_sequencer_if.slave bus
);

    seqState_e                       state_r, nextState_s;
    logic [TAP_W-1:0]                tapCnt_r, nextTap_s;
    logic                            loadAct_s;
    logic [NUM_BANKS-1:0][TAP_W-1:0] act_s;

    logic [NUM_BANKS-1:0]            csn_r, csnNext_s;
    logic                            wrn_r, wrnNext_s;
    logic [TAP_W-1:0]                addr_r, addrNext_s;
    logic signed [COEFF_W-1:0]       wrDt_r, wrDtNext_s;
    logic                            enDelay_r, enDelayNext_s;
    logic [NUM_BANKS-1:0]            fetchQual_r, fetchQualNext_s;
    logic                            fetchFirst_r, fetchFirstNext_s;
    logic [NUM_BANKS-1:0]            enMul_r, enAcc_r;
    logic                            enAdd_r, enAddNext_s;
    logic                            busy_r;

    fir_bank_active_calc uActCalc (
        .iClk_12M  (iClk_12M),
        .iRsn      (iRsn),
        .iLoad     (loadAct_s),
        .iNumCoeff (clampNcoef(bus.iNumOfCoeff)),
        .oAct      (act_s)
    );

    // State and tap counter registers.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            state_r  <= IDLE;
            tapCnt_r <= 4'd0;
        end else begin
            state_r  <= nextState_s;
            tapCnt_r <= nextTap_s;
        end
    end

    // Next-state decode and next values of every registered output.
    always_comb begin
        nextState_s      = state_r;
        nextTap_s        = tapCnt_r;
        loadAct_s        = 1'b0;
        csnNext_s        = '1;
        wrnNext_s        = 1'b1;
        addrNext_s       = 4'd0;
        wrDtNext_s       = 16'sd0;
        enDelayNext_s    = 1'b0;
        fetchQualNext_s  = '0;
        fetchFirstNext_s = 1'b0;
        enAddNext_s      = 1'b0;
        case (state_r)
            IDLE: begin
                // The update flag wins over a coincident strobe, which is lost.
                if (bus.iCoeffiUpdateFlag) begin
                    nextState_s = UPDATE;
                end else if (bus.iEnSample_600k) begin
                    nextState_s = FETCH;
                    nextTap_s   = 4'd0;
                    loadAct_s   = 1'b1;
                end else begin
                    nextState_s = IDLE;
                end
            end
            UPDATE: begin
                if (!bus.iCoeffiUpdateFlag) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = UPDATE;
                    wrnNext_s   = bus.iWrnRam;
                    addrNext_s  = bus.iAddrRam;
                    wrDtNext_s  = bus.iWrDtRam;
                    if (bus.iAddrRam <= 4'd9) begin
                        csnNext_s[bus.iBankSel] = bus.iCsnRam;
                    end else begin
                        csnNext_s = '1;
                    end
                end
            end
            FETCH: begin
                enDelayNext_s    = (tapCnt_r == 4'd0);
                fetchFirstNext_s = (tapCnt_r == 4'd0);
                addrNext_s       = tapCnt_r;
                for (int b = 0; b < NUM_BANKS; b++) begin
                    fetchQualNext_s[b] = (tapCnt_r < act_s[b]);
                end
                csnNext_s = ~fetchQualNext_s;
                if (tapCnt_r == 4'd9) begin
                    nextState_s = DRAIN;
                    nextTap_s   = 4'd0;
                end else begin
                    nextState_s = FETCH;
                    nextTap_s   = tapCnt_r + 4'd1;
                end
            end
            DRAIN: begin
                nextState_s = ADD;
            end
            ADD: begin
                enAddNext_s = 1'b1;
                if (bus.iCoeffiUpdateFlag) begin
                    nextState_s = UPDATE;
                end else begin
                    nextState_s = IDLE;
                end
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // Output registers; multiply enables trail the SRAM select by the read latency.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            csn_r        <= '1;
            wrn_r        <= 1'b1;
            addr_r       <= 4'd0;
            wrDt_r       <= 16'sd0;
            enDelay_r    <= 1'b0;
            fetchQual_r  <= '0;
            fetchFirst_r <= 1'b0;
            enMul_r      <= '0;
            enAcc_r      <= '0;
            enAdd_r      <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            csn_r        <= csnNext_s;
            wrn_r        <= wrnNext_s;
            addr_r       <= addrNext_s;
            wrDt_r       <= wrDtNext_s;
            enDelay_r    <= enDelayNext_s;
            fetchQual_r  <= fetchQualNext_s;
            fetchFirst_r <= fetchFirstNext_s;
            enMul_r      <= fetchQual_r;
            enAcc_r      <= fetchQual_r & ~{NUM_BANKS{fetchFirst_r}};
            enAdd_r      <= enAddNext_s;
            busy_r       <= (state_r != IDLE);
        end
    end

`ifdef FIR_SEQ_OVERRUN_EN
    logic overrun_r;

    // Sticky dropped-strobe flag; entering UPDATE takes priority and clears it.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            overrun_r <= 1'b0;
        end else if ((nextState_s == UPDATE) && (state_r != UPDATE)) begin
            overrun_r <= 1'b0;
        end else if (bus.iEnSample_600k &&
                     ((state_r == FETCH) || (state_r == DRAIN) || (state_r == ADD))) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign bus.oOverrun = overrun_r;
`else
    assign bus.oOverrun = 1'b0;
`endif

    assign bus.oCsnRam  = csn_r;
    assign bus.oWrnRam  = wrn_r;
    assign bus.oAddrRam = addr_r;
    assign bus.oWrDtRam = wrDt_r;
    assign bus.oEnDelay = enDelay_r;
    assign bus.oEnMul   = enMul_r;
    assign bus.oEnAcc   = enAcc_r;
    assign bus.oEnAdd   = enAdd_r;
    assign bus.oBusy    = busy_r;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: directed and random sweeps against a
// cycle-indexed reference, host update routing, overrun, and mid-sweep reset.
module tb_fir_mac_sequencer;
    import fir_seq_pkg::*;

`ifdef FIR_SEQ_OVERRUN_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   testsRun;
    int   failed;

    fir_mac_sequencer_if bus ();

    fir_mac_sequencer dut (
        .iClk_12M (clk),
        .iRsn     (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Active taps in bank b for a clamped coefficient count n.
    function automatic int actOf(input int n, input int b);
        int a;
        a = n - 10 * b;
        if (a < 0) a = 0;
        if (a > 10) a = 10;
        return a;
    endfunction

    // Expected {csn, addr, enDelay, enMul, enAcc, enAdd, busy, wrn} c cycles after the accepting edge.
    function automatic logic [19:0] expSweep(input int c, input int n, input bit flagHeld);
        logic [3:0] csn;
        logic [3:0] mul;
        logic [3:0] acc;
        logic [3:0] addr;
        logic       busy;
        csn  = 4'hF;
        mul  = 4'h0;
        acc  = 4'h0;
        addr = 4'h0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (c >= 1 && c <= 10 && (c - 1) < actOf(n, b)) csn[b] = 1'b0;
            if (c >= 2 && c <= 11 && (c - 2) < actOf(n, b)) begin
                mul[b] = 1'b1;
                acc[b] = (c > 2);
            end
        end
        if (c >= 1 && c <= 10) addr = 4'(c - 1);
        busy = (c >= 1 && c <= 12) || (flagHeld && c == 13);
        return {csn, addr, (c == 1), mul, acc, (c == 12), busy, 1'b1};
    endfunction

    function automatic logic [19:0] obsVec();
        return {bus.oCsnRam, bus.oAddrRam, bus.oEnDelay, bus.oEnMul, bus.oEnAcc,
                bus.oEnAdd, bus.oBusy, bus.oWrnRam};
    endfunction

    task automatic idleHost();
        bus.iCsnRam  = 1'b1;
        bus.iWrnRam  = 1'b1;
        bus.iBankSel = 2'd0;
        bus.iAddrRam = 4'd0;
        bus.iWrDtRam = 16'sd0;
    endtask

    task automatic runSweep(input int nRaw, input int extraAt, input int flagAt, input string tag);
        int n;
        int mulCnt [NUM_BANKS];
        int accCnt [NUM_BANKS];
        n = (nRaw > MAX_COEFF) ? MAX_COEFF : nRaw;
        foreach (mulCnt[b]) begin
            mulCnt[b] = 0;
            accCnt[b] = 0;
        end
        @(negedge clk);
        bus.iNumOfCoeff    = 6'(nRaw);
        bus.iEnSample_600k = 1'b1;
        @(negedge clk);
        bus.iEnSample_600k = 1'b0;
        for (int c = 0; c <= 13; c++) begin
            if (c > 0) @(negedge clk);
            check($sformatf("%s_n%0d_c%0d", tag, nRaw, c), 32'(obsVec()), 32'(expSweep(c, n, flagAt >= 0)));
            for (int b = 0; b < NUM_BANKS; b++) begin
                mulCnt[b] += int'(bus.oEnMul[b]);
                accCnt[b] += int'(bus.oEnAcc[b]);
            end
            bus.iEnSample_600k = (c == extraAt);
            if (c == flagAt) bus.iCoeffiUpdateFlag = 1'b1;
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            check($sformatf("%s_n%0d_mulcnt_b%0d", tag, nRaw, b), 32'(mulCnt[b]), 32'(actOf(n, b)));
            check($sformatf("%s_n%0d_acccnt_b%0d", tag, nRaw, b), 32'(accCnt[b]),
                  32'((actOf(n, b) > 0) ? actOf(n, b) - 1 : 0));
        end
    endtask

    initial begin
        logic                      seenAdd;
        logic                      seenBusy;
        logic                      rc;
        logic [1:0]                rb;
        logic [3:0]                ra;
        logic signed [COEFF_W-1:0] rd;
        logic [3:0]                ecsn;

        testsRun = 0;
        failed   = 0;
        rst_n    = 1'b0;
        bus.iEnSample_600k    = 1'b0;
        bus.iCoeffiUpdateFlag = 1'b0;
        bus.iNumOfCoeff       = 6'd0;
        idleHost();

        repeat (2) @(negedge clk);
        check("reset_vec", 32'(obsVec()), 32'({4'hF, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1}));
        check("reset_wrdt", 32'(bus.oWrDtRam), 32'd0);
        check("reset_ovr", 32'(bus.oOverrun), 32'd0);
        rst_n = 1'b1;

        runSweep(40, -1, -1, "full");
        runSweep(23, -1, -1, "part");
        runSweep(63, -1, -1, "clamp");
        runSweep(0,  -1, -1, "zero");
        repeat (4) runSweep(int'($urandom_range(0, 63)), -1, -1, "rnd");

        // Second strobe five cycles into a sweep is dropped.
        runSweep(17, 4, -1, "ovr");
        check("ovr_flag", 32'(bus.oOverrun), 32'(EXP_OVR));
        seenBusy = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seenBusy = seenBusy | bus.oBusy | bus.oEnDelay;
        end
        check("ovr_dropped", 32'(seenBusy), 32'd0);
        check("ovr_sticky", 32'(bus.oOverrun), 32'(EXP_OVR));

        // Flag raised mid-sweep: sweep completes, then UPDATE.
        runSweep(30, -1, 2, "flag");
        check("upd_ovr_clear", 32'(bus.oOverrun), 32'd0);
        bus.iEnSample_600k = 1'b1;
        @(negedge clk);
        bus.iEnSample_600k = 1'b0;
        seenAdd = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seenAdd = seenAdd | bus.oEnDelay;
        end
        check("upd_strobe_ignored", 32'(seenAdd), 32'd0);
        check("upd_busy", 32'(bus.oBusy), 32'd1);
        check("upd_no_ovr", 32'(bus.oOverrun), 32'd0);

        bus.iCsnRam  = 1'b0;
        bus.iWrnRam  = 1'b0;
        bus.iBankSel = 2'd2;
        bus.iAddrRam = 4'd3;
        bus.iWrDtRam = 16'sh1234;
        @(negedge clk);
        check("wr_csn", 32'(bus.oCsnRam), 32'(4'b1011));
        check("wr_wrn", 32'(bus.oWrnRam), 32'd0);
        check("wr_addr", 32'(bus.oAddrRam), 32'd3);
        check("wr_data", 32'(bus.oWrDtRam), 32'(16'sh1234));

        bus.iAddrRam = 4'd12;
        @(negedge clk);
        check("wr_addr12_csn", 32'(bus.oCsnRam), 32'hF);

        repeat (6) begin
            rc = 1'($urandom_range(0, 1));
            rb = 2'($urandom_range(0, 3));
            ra = 4'($urandom_range(0, 15));
            rd = 16'($urandom);
            bus.iCsnRam  = rc;
            bus.iWrnRam  = 1'($urandom_range(0, 1));
            bus.iBankSel = rb;
            bus.iAddrRam = ra;
            bus.iWrDtRam = rd;
            ecsn = 4'hF;
            if (!rc && ra <= 4'd9) ecsn[rb] = 1'b0;
            @(negedge clk);
            check($sformatf("rwr_csn_b%0d_a%0d", rb, ra), 32'(bus.oCsnRam), 32'(ecsn));
            check("rwr_data", 32'(bus.oWrDtRam), 32'(rd));
        end

        // Dropping the flag squashes a pending host access.
        bus.iCsnRam  = 1'b0;
        bus.iWrnRam  = 1'b0;
        bus.iAddrRam = 4'd1;
        bus.iCoeffiUpdateFlag = 1'b0;
        @(negedge clk);
        check("squash_csn", 32'(bus.oCsnRam), 32'hF);
        check("squash_wrn", 32'(bus.oWrnRam), 32'd1);
        idleHost();
        @(negedge clk);
        check("squash_idle", 32'(bus.oBusy), 32'd0);

        // Flag and strobe together in IDLE: strobe lost, no overrun.
        bus.iCoeffiUpdateFlag = 1'b1;
        bus.iEnSample_600k    = 1'b1;
        @(negedge clk);
        bus.iEnSample_600k = 1'b0;
        @(negedge clk);
        check("prio_no_delay", 32'(bus.oEnDelay), 32'd0);
        check("prio_no_ovr", 32'(bus.oOverrun), 32'd0);
        bus.iCoeffiUpdateFlag = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset while the sweep is at tap 4.
        bus.iNumOfCoeff    = 6'd40;
        bus.iEnSample_600k = 1'b1;
        @(negedge clk);
        bus.iEnSample_600k = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_vec", 32'(obsVec()), 32'({4'hF, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1}));
        check("midrst_ovr", 32'(bus.oOverrun), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        seenAdd  = 1'b0;
        seenBusy = 1'b0;
        repeat (16) begin
            @(negedge clk);
            seenAdd  = seenAdd | bus.oEnAdd;
            seenBusy = seenBusy | bus.oBusy;
        end
        check("midrst_no_add", 32'(seenAdd), 32'd0);
        check("midrst_no_busy", 32'(seenBusy), 32'd0);

        runSweep(40, -1, -1, "after_rst");

        $display("[TB] %0d tests run, %0d failed", testsRun, failed);
        $finish;
    end

endmodule
